// File: rtl/exception_ctrl_pkg.sv
// Shared codes, CP0 register numbers and FSM encodings for the MEM-stage exception controller.
package exception_ctrl_pkg;

  localparam logic [3:0] EXC_NONE = 4'h0;
  localparam logic [3:0] EXC_INT  = 4'h1;
  localparam logic [3:0] EXC_SYS  = 4'h8;
  localparam logic [3:0] EXC_RI   = 4'hA;
  localparam logic [3:0] EXC_TRAP = 4'hD;
  localparam logic [3:0] EXC_ERET = 4'hE;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Interrupt is pending when enabled (IE=1, EXL=0) and any unmasked IP bit is set.
  function automatic logic int_pending(input logic [31:0] st, input logic [31:0] ca);
    return st[0] & ~st[1] & (|(ca[15:8] & st[15:8]));
  endfunction

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// Fixed-priority encoder: int > RI > syscall > trap > eret, only the winner is reported.
module exc_prio_enc
  import exception_ctrl_pkg::*;
(
  input  logic       int_req,
  input  logic       ri,
  input  logic       sys,
  input  logic       trap,
  input  logic       eret,
  output logic [3:0] execode,
  output logic       any
);

  always_comb begin
    execode = EXC_NONE;
    if (int_req)   execode = EXC_INT;
    else if (ri)   execode = EXC_RI;
    else if (sys)  execode = EXC_SYS;
    else if (trap) execode = EXC_TRAP;
    else if (eret) execode = EXC_ERET;
  end

  assign any = int_req | ri | sys | trap | eret;

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception controller: picks one event per committing instruction, reports it to
// CP0, flushes the pipeline for FLUSH_CYCLES cycles and redirects fetch.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        in_dslot_i,
  input  logic        exc_ri_i,
  input  logic        exc_syscall_i,
  input  logic        exc_trap_i,
  input  logic        exc_eret_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        timer_int_i,
  output logic [3:0]  execode_o,
  output logic [31:0] current_pc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        redirect_o,
  output logic [31:0] exc_count_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              timer_q;
  logic [31:0]       exc_count;

  logic [31:0] st_eff;
  logic [31:0] ca_eff;
  logic [31:0] epc_eff;
  logic        int_req;
  logic [3:0]  code;
  logic        any_event;
  logic        accept;

  // An mtc0 in MEM this cycle must be visible to the decision made this cycle.
  always_comb begin
    st_eff  = status_i;
    ca_eff  = cause_i;
    epc_eff = epc_i;
    if (cp0_we_i && cp0_waddr_i == CP0_REG_STATUS) st_eff = cp0_wdata_i;
    if (cp0_we_i && cp0_waddr_i == CP0_REG_CAUSE)  ca_eff[9:8] = cp0_wdata_i[9:8];
    if (cp0_we_i && cp0_waddr_i == CP0_REG_EPC)    epc_eff = cp0_wdata_i;
    ca_eff[15] = ca_eff[15] | timer_q;
  end

  assign int_req = int_pending(st_eff, ca_eff);

  logic unused_bits;
  assign unused_bits = ^{st_eff[31:16], st_eff[7:2], ca_eff[31:16], ca_eff[7:0]};

  exc_prio_enc u_prio (
    .int_req (int_req),
    .ri      (exc_ri_i),
    .sys     (exc_syscall_i),
    .trap    (exc_trap_i),
    .eret    (exc_eret_i),
    .execode (code),
    .any     (any_event)
  );

  assign accept = ~rst & mem_valid_i & ~stall_i & (state == ST_IDLE) & any_event;

  assign execode_o    = accept ? code : EXC_NONE;
  assign current_pc_o = accept ? (in_dslot_i ? mem_pc_i - 32'd4 : mem_pc_i) : 32'd0;
  assign redirect_o   = accept;
  assign new_pc_o     = accept ? ((code == EXC_ERET) ? epc_eff : EXC_VECTOR) : 32'd0;
  assign flush_o      = ~rst & (accept | (state == ST_FLUSH));
  assign exc_count_o  = exc_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      timer_q   <= 1'b0;
      exc_count <= 32'd0;
    end else begin
      timer_q <= timer_int_i;
      if (accept && code != EXC_ERET) exc_count <= exc_count + 32'd1;
      case (state)
        ST_IDLE: begin
          if (accept && FLUSH_CYCLES > 1) begin
            state <= ST_FLUSH;
            cnt   <= CNT_LOAD;
          end
        end
        ST_FLUSH: begin
          // Leave when the counter reaches zero at this edge; stall does not hold it.
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed-vector bench for exception_ctrl with a queue-based scoreboard checked per cycle.
module tb_exception_ctrl;
  import exception_ctrl_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid_i = 1'b0, stall_i = 1'b0, in_dslot_i = 1'b0;
  logic [31:0] mem_pc_i = '0;
  logic        exc_ri_i = 1'b0, exc_syscall_i = 1'b0, exc_trap_i = 1'b0, exc_eret_i = 1'b0;
  logic        cp0_we_i = 1'b0;
  logic [4:0]  cp0_waddr_i = '0;
  logic [31:0] cp0_wdata_i = '0, status_i = '0, cause_i = '0, epc_i = '0;
  logic        timer_int_i = 1'b0;
  logic [3:0]  execode_o;
  logic [31:0] current_pc_o, new_pc_o, exc_count_o;
  logic        flush_o, redirect_o;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .stall_i(stall_i), .mem_pc_i(mem_pc_i),
    .in_dslot_i(in_dslot_i), .exc_ri_i(exc_ri_i), .exc_syscall_i(exc_syscall_i),
    .exc_trap_i(exc_trap_i), .exc_eret_i(exc_eret_i), .cp0_we_i(cp0_we_i),
    .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i), .status_i(status_i),
    .cause_i(cause_i), .epc_i(epc_i), .timer_int_i(timer_int_i), .execode_o(execode_o),
    .current_pc_o(current_pc_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .redirect_o(redirect_o), .exc_count_o(exc_count_o)
  );

  typedef struct {
    logic        rst, valid, stall, dslot, ri, sys, trap, eret, we, timer;
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata, status, cause, epc;
  } vec_t;

  typedef struct {
    int          step;
    logic [3:0]  code;
    logic [31:0] cpc;
    logic        flush;
    logic        flush_dc;
    logic        redir;
    logic [31:0] npc;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  function automatic vec_t base();
    vec_t v;
    v = '{rst: 1'b0, valid: 1'b1, stall: 1'b0, dslot: 1'b0, ri: 1'b0, sys: 1'b0, trap: 1'b0,
          eret: 1'b0, we: 1'b0, timer: 1'b0, pc: 32'h8000_0000, waddr: 5'd0, wdata: 32'd0,
          status: 32'h1000_0000, cause: 32'd0, epc: 32'd0};
    return v;
  endfunction

  task automatic step(input vec_t v, input logic [3:0] code, input logic [31:0] cpc,
                      input logic fl, input logic rd, input logic [31:0] npc,
                      input logic [31:0] cnt, input logic fl_dc = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = v.rst; mem_valid_i = v.valid; stall_i = v.stall; in_dslot_i = v.dslot;
    exc_ri_i = v.ri; exc_syscall_i = v.sys; exc_trap_i = v.trap; exc_eret_i = v.eret;
    cp0_we_i = v.we; cp0_waddr_i = v.waddr; cp0_wdata_i = v.wdata; mem_pc_i = v.pc;
    status_i = v.status; cause_i = v.cause; epc_i = v.epc; timer_int_i = v.timer;
    step_no++;
    e = '{step: step_no, code: code, cpc: cpc, flush: fl, flush_dc: fl_dc, redir: rd,
          npc: npc, cnt: cnt};
    sb.push_back(e);
  endtask

  task automatic idle(input logic fl, input logic [31:0] cnt);
    step(base(), EXC_NONE, 32'd0, fl, 1'b0, 32'd0, cnt);
  endtask

  task automatic cmp(input int stp, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL step=%0d %s actual=%h required=%h", stp, nm, act, req);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.step, "execode", {28'd0, execode_o}, {28'd0, e.code});
      cmp(e.step, "current_pc", current_pc_o, e.cpc);
      if (!e.flush_dc) cmp(e.step, "flush", {31'd0, flush_o}, {31'd0, e.flush});
      cmp(e.step, "redirect", {31'd0, redirect_o}, {31'd0, e.redir});
      cmp(e.step, "new_pc", new_pc_o, e.npc);
      cmp(e.step, "exc_count", exc_count_o, e.cnt);
      $display("step %0d: execode=%h cpc=%h flush=%0b redir=%0b npc=%h count=%0d",
               e.step, execode_o, current_pc_o, flush_o, redirect_o, new_pc_o, exc_count_o);
    end
  end

  initial begin
    vec_t v;
    v = base(); v.rst = 1'b1;
    step(v, EXC_NONE, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(v, EXC_NONE, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // syscall; flush held exactly 3 cycles
    v = base(); v.sys = 1'b1; v.pc = 32'h8000_0100;
    step(v, EXC_SYS, 32'h8000_0100, 1'b1, 1'b1, VEC, 32'd0);
    idle(1'b1, 32'd1); idle(1'b1, 32'd1); idle(1'b0, 32'd1);

    // RI + syscall + trap in a delay slot
    v = base(); v.ri = 1'b1; v.sys = 1'b1; v.trap = 1'b1; v.dslot = 1'b1; v.pc = 32'h8000_0200;
    step(v, EXC_RI, 32'h8000_01FC, 1'b1, 1'b1, VEC, 32'd1);
    idle(1'b1, 32'd2); idle(1'b1, 32'd2); idle(1'b0, 32'd2);

    // interrupt beats syscall; still pending during FLUSH but ignored
    v = base(); v.status = 32'h1000_0401; v.cause = 32'h0000_0400; v.sys = 1'b1;
    v.pc = 32'h8000_0300;
    step(v, EXC_INT, 32'h8000_0300, 1'b1, 1'b1, VEC, 32'd2);
    step(v, EXC_NONE, 32'd0, 1'b1, 1'b0, 32'd0, 32'd3);
    step(v, EXC_NONE, 32'd0, 1'b1, 1'b0, 32'd0, 32'd3);
    idle(1'b0, 32'd3);

    // mtc0 status clears IE in the same cycle: syscall wins instead
    v = base(); v.status = 32'h1000_0401; v.cause = 32'h0000_0400; v.sys = 1'b1;
    v.we = 1'b1; v.waddr = CP0_REG_STATUS; v.wdata = 32'h1000_0400; v.pc = 32'h8000_0400;
    step(v, EXC_SYS, 32'h8000_0400, 1'b1, 1'b1, VEC, 32'd3);
    idle(1'b1, 32'd4); idle(1'b1, 32'd4); idle(1'b0, 32'd4);

    // eret with EPC bypass; no count
    v = base(); v.eret = 1'b1; v.epc = 32'h0000_1000; v.we = 1'b1; v.waddr = CP0_REG_EPC;
    v.wdata = 32'h0000_2000; v.pc = 32'h8000_0500;
    step(v, EXC_ERET, 32'h8000_0500, 1'b1, 1'b1, 32'h0000_2000, 32'd4);
    idle(1'b1, 32'd4); idle(1'b1, 32'd4); idle(1'b0, 32'd4);

    // trap then RI while flushing
    v = base(); v.trap = 1'b1; v.pc = 32'h8000_0600;
    step(v, EXC_TRAP, 32'h8000_0600, 1'b1, 1'b1, VEC, 32'd4);
    v = base(); v.ri = 1'b1; v.pc = 32'h8000_0604;
    step(v, EXC_NONE, 32'd0, 1'b1, 1'b0, 32'd0, 32'd5);
    idle(1'b1, 32'd5); idle(1'b0, 32'd5);

    // stall in IDLE blocks the event
    v = base(); v.stall = 1'b1; v.sys = 1'b1; v.pc = 32'h8000_0700;
    step(v, EXC_NONE, 32'd0, 1'b0, 1'b0, 32'd0, 32'd5);
    idle(1'b0, 32'd5);

    // timer interrupt appears one cycle late through the registered copy
    v = base(); v.status = 32'h1000_8001; v.timer = 1'b1; v.pc = 32'h8000_0800;
    step(v, EXC_NONE, 32'd0, 1'b0, 1'b0, 32'd0, 32'd5);
    step(v, EXC_INT, 32'h8000_0800, 1'b1, 1'b1, VEC, 32'd5);
    idle(1'b1, 32'd6); idle(1'b1, 32'd6); idle(1'b0, 32'd6);

    // bubble in MEM
    v = base(); v.valid = 1'b0; v.sys = 1'b1;
    step(v, EXC_NONE, 32'd0, 1'b0, 1'b0, 32'd0, 32'd6);

    // reset on the 2nd flush cycle
    v = base(); v.sys = 1'b1; v.pc = 32'h8000_0900;
    step(v, EXC_SYS, 32'h8000_0900, 1'b1, 1'b1, VEC, 32'd6);
    idle(1'b1, 32'd7);
    v = base(); v.rst = 1'b1;
    step(v, EXC_NONE, 32'd0, 1'b0, 1'b0, 32'd0, 32'd7, 1'b1);
    idle(1'b0, 32'd0);

    // normal operation after reset
    v = base(); v.ri = 1'b1; v.pc = 32'h8000_0A00;
    step(v, EXC_RI, 32'h8000_0A00, 1'b1, 1'b1, VEC, 32'd0);
    idle(1'b1, 32'd1); idle(1'b1, 32'd1); idle(1'b0, 32'd1);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
